// File: rtl/regfile_scoreboard_if.sv
// Writeback-to-register-file write channel: one optional write per cycle.
// The writeback stage drives the master side; the register file consumes the slave side.
interface regfile_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int XLEN  = 64
);
  localparam int AW = $clog2(NREGS);

  // No handshake: reg_write_enable qualifies the address/data in the same
  // cycle, and the consumer always accepts the write on the next posedge.
  logic            reg_write_enable;
  logic [AW-1:0]   reg_dest_addr;
  logic [XLEN-1:0] reg_write_data;

  modport master (
    output reg_write_enable,
    output reg_dest_addr,
    output reg_write_data
  );

  modport slave (
    input reg_write_enable,
    input reg_dest_addr,
    input reg_write_data
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with two combinational read ports and a per-register pending-write counter.
// Optional macro REGFILE_WB_BYPASS_EN forwards a same-cycle writeback to the read ports.
module regfile_scoreboard #(
  parameter  int NREGS    = 32,
  parameter  int XLEN     = 64,
  parameter  int PEND_MAX = 3,
  localparam int AW       = $clog2(NREGS),
  localparam int CW       = $clog2(PEND_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_scoreboard_if.slave     wb_writer,
  input  logic [AW-1:0]           rs1_addr,
  input  logic [AW-1:0]           rs2_addr,
  output logic [XLEN-1:0]         rs1_data,
  output logic [XLEN-1:0]         rs2_data,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  input  logic                    issue_valid,
  input  logic                    issue_rd_en,
  input  logic [AW-1:0]           issue_rd,
  output logic                    issue_ready,
  input  logic                    flush,
  output logic [NREGS*XLEN-1:0]   regs_out
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [CW-1:0]   pend_q [NREGS];
  logic [CW-1:0]   pend_d [NREGS];
  logic [NREGS-1:0] inc_vec;
  logic [NREGS-1:0] dec_vec;

  logic wb_hit;
  logic retire_same_rd;
  logic issue_full;
  logic issue_fire;

  // x0 is never a write target, so every downstream use can rely on wb_hit.
  assign wb_hit = wb_writer.reg_write_enable && (wb_writer.reg_dest_addr != '0);

  // A retire on the issuing register frees one slot in the same cycle.
  assign retire_same_rd = wb_hit && (wb_writer.reg_dest_addr == issue_rd)
                          && (pend_q[issue_rd] != '0);
  assign issue_full  = issue_rd_en && (issue_rd != '0)
                       && (pend_q[issue_rd] == CW'(PEND_MAX)) && !retire_same_rd;
  assign issue_ready = !issue_full;
  assign issue_fire  = issue_valid && issue_rd_en && issue_ready && (issue_rd != '0);

  for (genvar g = 0; g < NREGS; g++) begin : g_pend_ctl
    assign inc_vec[g] = issue_fire && (issue_rd == AW'(g));
    assign dec_vec[g] = wb_hit && (wb_writer.reg_dest_addr == AW'(g))
                        && (pend_q[g] != '0);
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      pend_d[i] = pend_q[i];
      if (flush) begin
        pend_d[i] = '0;
      end else if (inc_vec[i] && !dec_vec[i] && (pend_q[i] != CW'(PEND_MAX))) begin
        pend_d[i] = pend_q[i] + CW'(1);
      end else if (dec_vec[i] && !inc_vec[i]) begin
        pend_d[i] = pend_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        pend_q[i] <= pend_d[i];
      end
      // Data lands even when a flush drops the pending marks this cycle.
      if (wb_hit) begin
        regs_q[wb_writer.reg_dest_addr] <= wb_writer.reg_write_data;
      end
    end
  end

  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
    rs1_busy = (pend_q[rs1_addr] != '0);
    rs2_busy = (pend_q[rs2_addr] != '0);
`ifdef REGFILE_WB_BYPASS_EN
    // The retiring write is consumed now, so only further in-flight writes keep the source busy.
    if (wb_hit && (wb_writer.reg_dest_addr == rs1_addr)) begin
      rs1_data = wb_writer.reg_write_data;
      rs1_busy = (pend_q[rs1_addr] > CW'(1));
    end
    if (wb_hit && (wb_writer.reg_dest_addr == rs2_addr)) begin
      rs2_data = wb_writer.reg_write_data;
      rs2_busy = (pend_q[rs2_addr] > CW'(1));
    end
`endif
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
    assign regs_out[g*XLEN +: XLEN] = regs_q[g];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed hazard scenarios followed by random traffic.
module tb_regfile_scoreboard;
  localparam int NREGS    = 32;
  localparam int XLEN     = 64;
  localparam int PEND_MAX = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [4:0]            rs1_addr, rs2_addr;
  logic [XLEN-1:0]       rs1_data, rs2_data;
  logic                  rs1_busy, rs2_busy;
  logic                  issue_valid, issue_rd_en;
  logic [4:0]            issue_rd;
  logic                  issue_ready;
  logic                  flush;
  logic [NREGS*XLEN-1:0] regs_out;

  regfile_scoreboard_if #(.NREGS(NREGS), .XLEN(XLEN)) wb_if ();

  regfile_scoreboard #(.NREGS(NREGS), .XLEN(XLEN), .PEND_MAX(PEND_MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_writer   (wb_if),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .issue_valid (issue_valid),
    .issue_rd_en (issue_rd_en),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .flush       (flush),
    .regs_out    (regs_out)
  );

  // reference model and scoreboard
  logic [XLEN-1:0] m_regs [NREGS];
  int              m_pend [NREGS];
  logic [XLEN-1:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_data(input logic [4:0] a, input bit we,
                                               input logic [4:0] wa, input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] v;
    v = (a == 5'd0) ? '0 : m_regs[a];
`ifdef REGFILE_WB_BYPASS_EN
    if (we && wa != 5'd0 && wa == a) v = wd;
`endif
    return v;
  endfunction

  function automatic bit exp_busy(input logic [4:0] a, input bit we, input logic [4:0] wa);
    bit b;
    b = (a != 5'd0) && (m_pend[a] != 0);
`ifdef REGFILE_WB_BYPASS_EN
    if (we && wa != 5'd0 && wa == a) b = (m_pend[a] > 1);
`endif
    return b;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
  endtask

  // driver: one cycle of stimulus, expected outputs queued, compared at negedge, model advanced
  task automatic step(input string name, input bit rst, input bit we, input logic [4:0] wa,
                      input logic [XLEN-1:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                      input bit iv, input bit ie, input logic [4:0] ird, input bit fl);
    bit rdy;
    reset = rst;
    wb_if.reg_write_enable = we;
    wb_if.reg_dest_addr    = wa;
    wb_if.reg_write_data   = wd;
    rs1_addr = a1;
    rs2_addr = a2;
    issue_valid = iv;
    issue_rd_en = ie;
    issue_rd    = ird;
    flush       = fl;

    rdy = !(ie && ird != 5'd0 && m_pend[ird] == PEND_MAX && !(we && wa == ird));
    exp_q.push_back(exp_data(a1, we, wa, wd));
    exp_q.push_back(exp_data(a2, we, wa, wd));
    exp_q.push_back(XLEN'(exp_busy(a1, we, wa)));
    exp_q.push_back(XLEN'(exp_busy(a2, we, wa)));
    exp_q.push_back(XLEN'(rdy));

    @(negedge clk);
    check_val({name, ".rs1_data"},    rs1_data,           exp_q.pop_front());
    check_val({name, ".rs2_data"},    rs2_data,           exp_q.pop_front());
    check_val({name, ".rs1_busy"},    XLEN'(rs1_busy),    exp_q.pop_front());
    check_val({name, ".rs2_busy"},    XLEN'(rs2_busy),    exp_q.pop_front());
    check_val({name, ".issue_ready"}, XLEN'(issue_ready), exp_q.pop_front());

    if (rst) begin
      clear_model();
    end else begin
      if (we && wa != 5'd0) m_regs[wa] = wd;
      if (fl) begin
        for (int i = 0; i < NREGS; i++) m_pend[i] = 0;
      end else begin
        if (we && wa != 5'd0 && m_pend[wa] > 0) m_pend[wa]--;
        if (iv && ie && rdy && ird != 5'd0) m_pend[ird]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_array(input string name);
    for (int i = 0; i < NREGS; i++) begin
      check_val($sformatf("%s.regs_out[%0d]", name, i), regs_out[i*XLEN +: XLEN], m_regs[i]);
    end
  endtask

  initial begin
    reset = 1'b1;
    wb_if.reg_write_enable = 1'b0;
    wb_if.reg_dest_addr    = '0;
    wb_if.reg_write_data   = '0;
    rs1_addr = '0; rs2_addr = '0;
    issue_valid = 1'b0; issue_rd_en = 1'b0; issue_rd = '0; flush = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;

    // reset state
    step("reset_read", 0, 0, 0, '0, 5, 0, 0, 0, 0, 0);
    check_array("reset");

    // issue, busy, retire
    step("t2_issue",  0, 0, 0, '0,          0, 0, 1, 1, 7, 0);
    step("t2_busy",   0, 0, 0, '0,          7, 0, 0, 0, 0, 0);
    step("t2_wb",     0, 1, 7, 64'hDEAD,    7, 0, 0, 0, 0, 0);
    step("t2_after",  0, 0, 0, '0,          7, 0, 0, 0, 0, 0);

    // same-cycle write-to-read
    step("t3_issue",  0, 0, 0, '0,          0, 0, 1, 1, 7, 0);
    step("t3_byp",    0, 1, 7, 64'h1234,    7, 7, 0, 0, 0, 0);
    step("t3_after",  0, 0, 0, '0,          7, 0, 0, 0, 0, 0);

    // saturation on x3
    for (int i = 0; i < 4; i++) step($sformatf("t4_issue%0d", i), 0, 0, 0, '0, 3, 0, 1, 1, 3, 0);
    step("t4_ret_iss", 0, 1, 3, 64'h33,     3, 0, 1, 1, 3, 0);
    step("t4_full",    0, 0, 0, '0,         3, 0, 1, 1, 3, 0);
    for (int i = 0; i < 3; i++) step($sformatf("t4_drain%0d", i), 0, 1, 3, 64'h300 + 64'(i), 3, 0, 0, 0, 0, 0);
    step("t4_empty",   0, 0, 0, '0,         3, 0, 0, 1, 3, 0);

    // x0 ignores writes and issues
    step("t5_x0",      0, 1, 0, 64'hFFFF,   0, 0, 1, 1, 0, 0);
    step("t5_read",    0, 0, 0, '0,         0, 0, 0, 1, 0, 0);

    // flush drops pending marks, data write still lands
    step("t6_iss4a",   0, 0, 0, '0,         0, 0, 1, 1, 4, 0);
    step("t6_iss4b",   0, 0, 0, '0,         0, 0, 1, 1, 4, 0);
    step("t6_iss9",    0, 0, 0, '0,         4, 0, 1, 1, 9, 0);
    step("t6_flush",   0, 1, 9, 64'h99,     4, 9, 1, 1, 4, 1);
    step("t6_post",    0, 0, 0, '0,         4, 9, 0, 0, 0, 0);
    step("t6_wb4",     0, 1, 4, 64'h44,     4, 9, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step($sformatf("t6_refill%0d", i), 0, 0, 0, '0, 4, 9, 1, 1, 4, 0);
    check_array("directed");

    // random traffic over a small register window so counters saturate often
    for (int n = 0; n < 400; n++) begin
      step($sformatf("rnd%0d", n),
           ($urandom_range(0, 79) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 15) == 0));
    end
    check_array("random");

    // reset mid-operation discards data and pending marks
    step("mid_issue",  0, 1, 5, 64'h55,     0, 0, 1, 1, 6, 0);
    step("mid_reset",  1, 1, 6, 64'h66,     5, 6, 1, 1, 6, 1);
    step("post_reset", 0, 0, 0, '0,         5, 6, 0, 1, 6, 0);
    check_array("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
